lock_controller: RTL
====================

// Module: lock_controller
// PURPOSE
//  Door-lock sequencer. It consumes the synchronised keypad code and strobe from synckey
//  (key value plus a level strobe held while the key is down), collects passcode digits,
//  checks them against the stored code, and drives the unlock, alarm and relock timing.
//  It sits between synckey and the ssdec displays / status LEDs in top.
// PARAMETERS
//  CODE_LEN     4        passcode length in decimal digits
//  MAX_TRIES    3        consecutive failed checks that trigger ALARM
//  OPEN_TICKS   500      clk cycles unlocked before auto-relock (5 s at hz100)
//  ALARM_TICKS  1000     clk cycles spent in ALARM
//  DEFAULT_CODE 16'h1234 reset passcode, BCD, one nibble per digit, MSD first
// PORTS
//  clk        in   1            system clock (hz100 in top)
//  rst        in   1            synchronous reset, active-high
//  key        in   5            key code from synckey: 0-15 hex keys, 16 ENTER, 17 CLEAR, 18 SET
//  key_strobe in   1            level strobe from synckey, high while a key is held
//  unlocked   out  1            door released
//  alarm      out  1            alarm active
//  state      out  3            current state_t (debug/display)
//  entry      out  4*CODE_LEN   digits entered so far, BCD, newest digit in low nibble (to ssdec)
//  digit_cnt  out  $clog2(CODE_LEN+1)  digits held, saturates at CODE_LEN
//  fail_cnt   out  $clog2(MAX_TRIES+1) consecutive failures
// BEHAVIOUR
//  - All outputs are registered. Reset: state LOCKED, unlocked=0, alarm=0, entry=0,
//    digit_cnt=0, fail_cnt=0, timer=0, code=DEFAULT_CODE, strobe_q=1.
//  - Key event = key_strobe & ~strobe_q, so there is one event per press however long the key
//    is held. strobe_q resets to 1, so a key held through reset produces no event.
//  - LOCKED:
//    - digit (key<=9): entry <= {entry[4*CODE_LEN-5:0], key[3:0]}; digit_cnt++ saturating.
//      Older digits fall off the top.
//    - Keys 10-15 and SET: ignored.
//    - CLEAR: entry=0, digit_cnt=0.
//    - ENTER: -> CHECK.
//  - CHECK (1 cycle):
//    - Match = (digit_cnt==CODE_LEN) && (entry==code). Entry and digit_cnt clear on exit.
//    - Match: -> OPEN, timer=OPEN_TICKS-1, fail_cnt=0.
//    - Mismatch with fail_cnt+1==MAX_TRIES: -> ALARM, timer=ALARM_TICKS-1, fail_cnt=0.
//    - Other mismatch: fail_cnt++, -> LOCKED.
//    - Key events arriving in CHECK are dropped.
//  - Latency: ENTER edge registered at cycle n; CHECK at n+1; unlocked/alarm valid at n+2.
//  - OPEN: unlocked=1; timer decrements each cycle.
//    - Timer==0 -> LOCKED.
//    - ENTER or CLEAR event -> LOCKED immediately (manual relock). Digits are ignored.
//  - ALARM: alarm=1; all key events ignored; timer==0 -> LOCKED.
//  - unlocked and alarm are never high together. Reset mid-operation restores all reset
//    values, including code.
// CONFIGURATION
//  LOCK_PROGRAM_EN defined:
//  - SET event in OPEN -> SET_CODE and clears entry.
//  - SET_CODE: unlocked stays 1 and the timer keeps running. Digits shift in as in LOCKED.
//  - ENTER with digit_cnt==CODE_LEN: code <= entry, -> LOCKED.
//  - ENTER with fewer digits: ignored.
//  - CLEAR or timer==0: -> LOCKED with code unchanged.
//  LOCK_PROGRAM_EN undefined: SET_CODE is unreachable, SET is ignored everywhere, and code
//  is the constant DEFAULT_CODE.
// STRUCTURE
//  - lock_pkg: state_t enum {LOCKED, CHECK, OPEN, ALARM, SET_CODE}; KEY_ENTER=5'd16,
//    KEY_CLEAR=5'd17, KEY_SET=5'd18.
//  - Sub-module lock_timer: loadable down-counter with load, load value and zero flag,
//    width $clog2(max(OPEN_TICKS,ALARM_TICKS)).
// TESTING
//  1. Reset; 1,2,3,4,ENTER -> unlocked=1 two cycles after the ENTER edge, held 500 cycles,
//     then 0 and state=LOCKED.
//  2. 1,2,3,5,ENTER three times -> fail_cnt 1 then 2; third attempt gives alarm=1 for 1000
//     cycles, 1234+ENTER during ALARM ignored, then LOCKED with fail_cnt=0.
//  3. Hold key 7 for 50 cycles -> digit_cnt=1, entry=16'h0007. Then 9,1,2,3,4,ENTER ->
//     unlocks (last four digits kept).
//  4. 1,2,ENTER -> mismatch, fail_cnt=1. CLEAR mid-entry -> entry=0.
//     ENTER while OPEN -> unlocked=0 next cycle.
//  5. (LOCK_PROGRAM_EN) Open with 1234; SET,9,8,7,6,ENTER -> LOCKED. 1234 then fails and
//     9876 opens. Reset restores 1234.
//  6. Reset asserted mid-OPEN with key_strobe held -> next cycle unlocked=0, state=LOCKED,
//     and no key event after reset deasserts.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and key codes for the door-lock sequencer.
// SET_CODE is only reachable when LOCK_PROGRAM_EN is defined.
package lock_pkg;

    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        CHECK    = 3'd1,
        OPEN     = 3'd2,
        ALARM    = 3'd3,
        SET_CODE = 3'd4
    } state_t;

    localparam logic [4:0] KEY_ENTER = 5'd16;
    localparam logic [4:0] KEY_CLEAR = 5'd17;
    localparam logic [4:0] KEY_SET   = 5'd18;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero.
// It paces the unlock window and the alarm hold time.
module lock_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad passcode sequencer: collects digits, checks the code, times unlock and alarm.
// Define LOCK_PROGRAM_EN to allow reprogramming the code from the OPEN state.
module lock_controller #(
    parameter int                      CODE_LEN     = 4,
    parameter int                      MAX_TRIES    = 3,
    parameter int                      OPEN_TICKS   = 500,
    parameter int                      ALARM_TICKS  = 1000,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [4:0]                        key,
    input  logic                              key_strobe,
    output logic                              unlocked,
    output logic                              alarm,
    output logic [2:0]                        state,
    output logic [4*CODE_LEN-1:0]             entry,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt
);

    import lock_pkg::*;

    localparam int EW = 4 * CODE_LEN;
    localparam int DW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(OPEN_TICKS > ALARM_TICKS ? OPEN_TICKS : ALARM_TICKS);

    localparam logic [DW-1:0] DMAX  = DW'(CODE_LEN);
    localparam logic [FW-1:0] FLAST = FW'(MAX_TRIES - 1);
    localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0] T_ALARM = TW'(ALARM_TICKS - 1);

    state_t          state_q, state_n;
    logic [EW-1:0]   entry_q, entry_n;
    logic [DW-1:0]   dcnt_q, dcnt_n;
    logic [FW-1:0]   fcnt_q, fcnt_n;
    logic            unlocked_q, alarm_q;
    logic            strobe_q;
    logic [EW-1:0]   code;

    logic            ev;
    logic            is_digit;
    logic [EW-1:0]   shifted;
    logic [DW-1:0]   dinc;
    logic            match;
    logic            t_load;
    logic [TW-1:0]   t_value;
    logic            t_zero;

    assign ev       = key_strobe & ~strobe_q;
    assign is_digit = (key <= 5'd9);
    assign shifted  = {entry_q[EW-5:0], key[3:0]};
    assign dinc     = (dcnt_q == DMAX) ? DMAX : dcnt_q + 1'b1;
    assign match    = (dcnt_q == DMAX) && (entry_q == code);

`ifdef LOCK_PROGRAM_EN
    logic [EW-1:0] code_q, code_n;
    assign code = code_q;
`else
    assign code = DEFAULT_CODE;
`endif

    lock_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (t_load),
        .load_value (t_value),
        .zero       (t_zero)
    );

    always_comb begin
        state_n = state_q;
        entry_n = entry_q;
        dcnt_n  = dcnt_q;
        fcnt_n  = fcnt_q;
        t_load  = 1'b0;
        t_value = '0;
`ifdef LOCK_PROGRAM_EN
        code_n  = code_q;
`endif
        unique case (state_q)
            LOCKED: begin
                if (ev) begin
                    if (key == KEY_ENTER) begin
                        state_n = CHECK;
                    end else if (key == KEY_CLEAR) begin
                        entry_n = '0;
                        dcnt_n  = '0;
                    end else if (is_digit) begin
                        entry_n = shifted;
                        dcnt_n  = dinc;
                    end
                end
            end
            CHECK: begin
                entry_n = '0;
                dcnt_n  = '0;
                if (match) begin
                    state_n = OPEN;
                    t_load  = 1'b1;
                    t_value = T_OPEN;
                    fcnt_n  = '0;
                end else if (fcnt_q == FLAST) begin
                    state_n = ALARM;
                    t_load  = 1'b1;
                    t_value = T_ALARM;
                    fcnt_n  = '0;
                end else begin
                    state_n = LOCKED;
                    fcnt_n  = fcnt_q + 1'b1;
                end
            end
            OPEN: begin
                if (t_zero) begin
                    state_n = LOCKED;
                end else if (ev) begin
                    if (key == KEY_ENTER || key == KEY_CLEAR) begin
                        state_n = LOCKED;
                    end else if (key == KEY_SET) begin
`ifdef LOCK_PROGRAM_EN
                        state_n = SET_CODE;
                        entry_n = '0;
                        dcnt_n  = '0;
`endif
                    end
                end
            end
            ALARM: begin
                if (t_zero) begin
                    state_n = LOCKED;
                end
            end
            SET_CODE: begin
`ifdef LOCK_PROGRAM_EN
                // Any exit leaves the entry buffer empty for the next attempt.
                if (t_zero || (ev && key == KEY_CLEAR)) begin
                    state_n = LOCKED;
                    entry_n = '0;
                    dcnt_n  = '0;
                end else if (ev) begin
                    if (key == KEY_ENTER) begin
                        if (dcnt_q == DMAX) begin
                            code_n  = entry_q;
                            state_n = LOCKED;
                            entry_n = '0;
                            dcnt_n  = '0;
                        end
                    end else if (is_digit) begin
                        entry_n = shifted;
                        dcnt_n  = dinc;
                    end
                end
`else
                state_n = LOCKED;
`endif
            end
            default: begin
                state_n = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOCKED;
            entry_q    <= '0;
            dcnt_q     <= '0;
            fcnt_q     <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            strobe_q   <= 1'b1;
        end else begin
            state_q    <= state_n;
            entry_q    <= entry_n;
            dcnt_q     <= dcnt_n;
            fcnt_q     <= fcnt_n;
            unlocked_q <= (state_n == OPEN) || (state_n == SET_CODE);
            alarm_q    <= (state_n == ALARM);
            strobe_q   <= key_strobe;
        end
    end

`ifdef LOCK_PROGRAM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= DEFAULT_CODE;
        end else begin
            code_q <= code_n;
        end
    end
`endif

    assign unlocked  = unlocked_q;
    assign alarm     = alarm_q;
    assign state     = state_q;
    assign entry     = entry_q;
    assign digit_cnt = dcnt_q;
    assign fail_cnt  = fcnt_q;

endmodule
